// File: rtl/shift_add_mul_ctrl.sv
// rtl/shift_add_mul_ctrl.sv - sequential shift-and-add unsigned multiplier with start/busy/done handshake
// Optional build macro ZERO_SKIP_EN: zero operands bypass the iteration loop.
module shift_add_mul_ctrl #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        SKIP = 2'd3
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mq_q;
    logic [WIDTH:0]     hi_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] product_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     hi_d;
    logic [WIDTH-1:0]   mq_d;

    // hi_q[WIDTH] is always zero after a shift, so adding the full hi_q equals hi[WIDTH-1:0].
    always_comb begin
        sum_d = hi_q + {1'b0, (mq_q[0] ? mcand_q : {WIDTH{1'b0}})};
        hi_d  = {1'b0, sum_d[WIDTH:1]};
        mq_d  = {sum_d[0], mq_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mq_q      <= '0;
            hi_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= a;
                        mq_q    <= b;
                        hi_q    <= '0;
                        cnt_q   <= '0;
`ifdef ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            state_q   <= SKIP;
                            product_q <= '0;
                        end else
`endif
                        begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    hi_q  <= hi_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        product_q <= {hi_d[WIDTH-1:0], mq_d};
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                SKIP: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
